id_hazard_ctrl: RTL and testbench
=================================

// Module: id_hazard_ctrl
// PURPOSE
//  Scoreboard/issue controller in front of the decode stage and its register file.
//  - Tracks destination registers (inst[27:22]) of instructions in flight between issue and retirement.
//  - Holds decode (stall) while a source register it reads still has a pending write.
//  - Keeps a stall-cycle counter, a deadlock watchdog and a sticky error flag.
// PARAMETERS
//  REGW      6        register index width (64 architectural registers, all tracked, none hardwired)
//  CNTW      2        per-register pending-write counter width (max 2**CNTW-1 in flight per reg)
//  WB_MASK   16'h00FF bit k=1: opcode k writes rd
//  RS1_MASK  16'h00FF bit k=1: opcode k reads rs1 (inst[21:16]) when svpc=0
//  RS2_MASK  16'h000F bit k=1: opcode k reads rs2 (inst[15:10])
//  STALL_MAX 256      consecutive stall cycles that trip the watchdog
// PORTS
//  clk        in   1   clock, all state updates on posedge
//  rst        in   1   synchronous, active-high reset
//  id_valid   in   1   decode holds a valid instruction
//  inst       in   32  instruction in decode: [31:28] opcode, [27:22] rd, [21:16] rs1, [15:10] rs2
//  svpc       in   1   lhs operand is the PC; rs1 not read regardless of RS1_MASK
//  wb_done    in   1   a tracked writer leaves the pipeline this cycle (written back or squashed)
//  wb_rd      in   6   destination of that retiring writer
//  stall      out  1   combinational: decode must hold inst this cycle
//  issue      out  1   combinational: id_valid & ~stall; instruction advances at this edge
//  busy       out  1   registered: any per-register count nonzero
//  stall_cnt  out  16  registered saturating count of cycles with stall=1
//  deadlock   out  1   registered sticky: stall held STALL_MAX consecutive cycles
//  sb_err     out  1   registered sticky: wb_done on a register whose count is 0
// BEHAVIOUR
//  Reset: all 64 counts 0, stall_cnt 0, run counter 0, deadlock 0, sb_err 0; hence stall=0, issue=id_valid, busy=0.
//  Decode: op = inst[31:28].
//   - writes = WB_MASK[op]
//   - r1 = RS1_MASK[op] & ~svpc
//   - r2 = RS2_MASK[op]
//  Stall is asserted when id_valid and any of the following holds:
//   - r1 and cnt[rs1] != 0
//   - r2 and cnt[rs2] != 0
//   - writes and cnt[rd] == max (saturation guard)
//  No bypass: stall reads registered counts only. A wb_done that clears a blocking register
//   lets the stalled instruction issue on the following cycle (1-cycle wakeup latency).
//  Count update per posedge:
//   - inc = issue & writes, on rd
//   - dec = wb_done & cnt[wb_rd] != 0, on wb_rd
//   - same register, inc and dec together: count unchanged
//   - different registers: both apply
//  Underflow: wb_done with cnt[wb_rd]==0: count stays 0, sb_err<=1 (sticky until rst).
//  A WAW on rd alone never stalls. WAR never stalls (in-order read at decode).
//  stall_cnt increments each cycle stall=1 and holds at 16'hFFFF.
//  Watchdog: the run counter increments while stall=1 and clears when stall=0.
//   - deadlock<=1 when run reaches STALL_MAX; sticky, does not block issue.
//  busy is next-state registered: 1 iff any count is nonzero after this edge's update.
//  id_valid=0: stall=0, issue=0; counts change only by wb_done; the run counter clears.
//  rst mid-operation clears all state the same cycle regardless of other inputs;
//   in-flight writers retiring after reset raise sb_err.
// TESTING
//  1 After reset, issue op0 rd=5 writer; next cycle op0 rs1=5 -> stall=1, issue=0.
//    wb_done rd=5 -> stall=0 the cycle after.
//  2 svpc=1 with rs1=5 pending, rs2 free -> stall=0, issue=1.
//    Same case with svpc=0 -> stall=1.
//  3 Three writers to rd=9 back to back -> cnt[9]=3; 4th writer to rd=9 stalls.
//    One wb_done rd=9 -> 4th issues next cycle, cnt stays 3.
//  4 Same edge: issue writer rd=7 and wb_done rd=7 with cnt=1 -> cnt stays 1, busy=1.
//  5 wb_done rd=12 with cnt 0 -> sb_err=1, counts unchanged; rst -> sb_err=0, busy=0.
//  6 Hold a dependent stall 256 cycles -> deadlock=1 at cycle 256, stall_cnt=256.
//    Release -> deadlock stays 1.

Source files
------------

// File: rtl/id_hazard_ctrl_if.sv
// Decode/writeback bus between the decode stage and the hazard controller.
//   master : decode side; drives the instruction in decode and the retiring-writer report,
//            receives stall/issue and the status outputs.
//   slave  : hazard controller; the mirror image.
// Signals:
//   id_valid  - decode holds a valid instruction
//   inst      - instruction in decode ([31:28] opcode, [27:22] rd, [21:16] rs1, [15:10] rs2)
//   svpc      - lhs operand is the PC, rs1 is not read
//   wb_done   - a tracked writer leaves the pipeline this cycle
//   wb_rd     - destination register of that writer
//   stall     - decode must hold inst this cycle
//   issue     - instruction advances at this edge
//   busy      - any register has a pending write
//   stall_cnt - saturating count of stalled cycles
//   deadlock  - sticky watchdog flag
//   sb_err    - sticky scoreboard underflow flag
interface id_hazard_ctrl_if #(
    parameter int unsigned REGW = 6
);
    logic            id_valid;
    logic [31:0]     inst;
    logic            svpc;
    logic            wb_done;
    logic [REGW-1:0] wb_rd;
    logic            stall;
    logic            issue;
    logic            busy;
    logic [15:0]     stall_cnt;
    logic            deadlock;
    logic            sb_err;

    modport master (
        output id_valid, inst, svpc, wb_done, wb_rd,
        input  stall, issue, busy, stall_cnt, deadlock, sb_err
    );

    modport slave (
        input  id_valid, inst, svpc, wb_done, wb_rd,
        output stall, issue, busy, stall_cnt, deadlock, sb_err
    );
endinterface

// File: rtl/id_hazard_ctrl.sv
// Scoreboard / issue controller in front of the decode stage.
// Tracks a pending-write count per architectural register, stalls decode while a source it
// reads (or its destination, when saturated) is still pending, and keeps a stall-cycle
// counter, a deadlock watchdog and a sticky underflow error flag.
// Ports:
//   clk  - clock, all state updates on posedge
//   rst  - synchronous active-high reset
//   bus  - id_hazard_ctrl_if slave modport (decode request, writeback report, status outputs)
module id_hazard_ctrl #(
    parameter int unsigned REGW      = 6,
    parameter int unsigned CNTW      = 2,
    parameter logic [15:0] WB_MASK   = 16'h00FF,
    parameter logic [15:0] RS1_MASK  = 16'h00FF,
    parameter logic [15:0] RS2_MASK  = 16'h000F,
    parameter int unsigned STALL_MAX = 256
) (
    input logic              clk,
    input logic              rst,
    id_hazard_ctrl_if.slave  bus
);

    localparam int unsigned NumRegs = 1 << REGW;
    localparam int unsigned RunW    = $clog2(STALL_MAX + 1);
    localparam logic [RunW-1:0] RunMax = RunW'(STALL_MAX);

    // Instruction field decode
    logic [3:0]      op;
    logic [REGW-1:0] rd, rs1, rs2;
    logic            writes, rd_rs1, rd_rs2;
    logic            unused_inst;

    assign op          = bus.inst[31:28];
    assign rd          = bus.inst[27:22];
    assign rs1         = bus.inst[21:16];
    assign rs2         = bus.inst[15:10];
    assign unused_inst = ^bus.inst[9:0];

    assign writes = WB_MASK[op];
    assign rd_rs1 = RS1_MASK[op] & ~bus.svpc;
    assign rd_rs2 = RS2_MASK[op];

    // State
    logic [CNTW-1:0] cnt_q [NumRegs];
    logic [CNTW-1:0] cnt_d [NumRegs];
    logic [15:0]     stall_cnt_q, stall_cnt_d;
    logic [RunW-1:0] run_q, run_d;
    logic            deadlock_q, deadlock_d;
    logic            sb_err_q, sb_err_d;
    logic            busy_q, busy_d;

    // Hazard detection reads registered counts only; no bypass from wb_done.
    logic stall, issue;
    logic hz_rs1, hz_rs2, hz_sat;

    assign hz_rs1 = rd_rs1 & (cnt_q[rs1] != '0);
    assign hz_rs2 = rd_rs2 & (cnt_q[rs2] != '0);
    assign hz_sat = writes & (cnt_q[rd] == '1);
    assign stall  = bus.id_valid & (hz_rs1 | hz_rs2 | hz_sat);
    assign issue  = bus.id_valid & ~stall;

    // One-hot increment / decrement selects for the count array
    logic                wb_hit;
    logic [NumRegs-1:0]  inc_vec, dec_vec;
    localparam logic [NumRegs-1:0] OneHot0 = NumRegs'(1);

    assign wb_hit  = cnt_q[bus.wb_rd] != '0;
    assign inc_vec = (issue & writes) ? (OneHot0 << rd) : '0;
    assign dec_vec = (bus.wb_done & wb_hit) ? (OneHot0 << bus.wb_rd) : '0;

    always_comb begin
        busy_d = 1'b0;
        for (int unsigned i = 0; i < NumRegs; i++) begin
            cnt_d[i] = cnt_q[i];
            // inc and dec on the same register cancel out
            if (inc_vec[i] & ~dec_vec[i]) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end else if (dec_vec[i] & ~inc_vec[i]) begin
                cnt_d[i] = cnt_q[i] - 1'b1;
            end
            busy_d = busy_d | (cnt_d[i] != '0);
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end

        // Run length of the current stall streak, held once it reaches the trip point
        run_d = '0;
        if (stall) begin
            run_d = (run_q >= RunMax) ? run_q : run_q + 1'b1;
        end

        deadlock_d = deadlock_q | (run_d >= RunMax);
        sb_err_d   = sb_err_q | (bus.wb_done & ~wb_hit);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NumRegs; i++) begin
                cnt_q[i] <= '0;
            end
            stall_cnt_q <= '0;
            run_q       <= '0;
            deadlock_q  <= 1'b0;
            sb_err_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
            run_q       <= run_d;
            deadlock_q  <= deadlock_d;
            sb_err_q    <= sb_err_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.stall     = stall;
    assign bus.issue     = issue;
    assign bus.busy      = busy_q;
    assign bus.stall_cnt = stall_cnt_q;
    assign bus.deadlock  = deadlock_q;
    assign bus.sb_err    = sb_err_q;

endmodule

// File: tb/tb_id_hazard_ctrl.sv
module tb_id_hazard_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    id_hazard_ctrl_if bus ();

    id_hazard_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: plain per-register pending-write counts and status values
    int m_cnt [64];
    int m_stall_cnt = 0;
    int m_run       = 0;
    bit m_dead      = 1'b0;
    bit m_err       = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Opcodes 0..7 write rd and read rs1; opcodes 0..3 also read rs2. Max 3 writes per reg.
    function automatic bit m_stall_f(input bit v, input int op, input int rd, input int rs1,
                                     input int rs2, input bit sv);
        if (!v) return 1'b0;
        if (op < 8 && !sv && m_cnt[rs1] != 0) return 1'b1;
        if (op < 4 && m_cnt[rs2] != 0) return 1'b1;
        if (op < 8 && m_cnt[rd] == 3) return 1'b1;
        return 1'b0;
    endfunction

    // One clock cycle: drive at negedge, check combinational outputs, clock, update model,
    // check registered outputs. want_stall >= 0 adds a directed expectation for stall.
    task automatic cyc(input bit r, input bit v, input int op, input int rd, input int rs1,
                       input int rs2, input bit sv, input bit wbd, input int wr,
                       input int want_stall);
        bit st;
        int old;
        bit any;
        logic [31:0] opv, rdv, rs1v, rs2v;
        opv  = op;
        rdv  = rd;
        rs1v = rs1;
        rs2v = rs2;
        rst          = r;
        bus.id_valid = v;
        bus.inst     = {opv[3:0], rdv[5:0], rs1v[5:0], rs2v[5:0], 10'd0};
        bus.svpc     = sv;
        bus.wb_done  = wbd;
        bus.wb_rd    = 6'(wr);
        #1;
        st = m_stall_f(v, op, rd, rs1, rs2, sv);
        chk("stall", {31'd0, bus.stall}, {31'd0, st});
        chk("issue", {31'd0, bus.issue}, {31'd0, v && !st});
        if (want_stall >= 0) chk("dir_stall", {31'd0, bus.stall}, want_stall);
        @(posedge clk);
        if (r) begin
            foreach (m_cnt[i]) m_cnt[i] = 0;
            m_stall_cnt = 0;
            m_run       = 0;
            m_dead      = 1'b0;
            m_err       = 1'b0;
        end else begin
            old = m_cnt[wr];
            if (v && !st && op < 8) m_cnt[rd]++;
            if (wbd) begin
                if (old > 0) m_cnt[wr]--;
                else m_err = 1'b1;
            end
            if (st) begin
                if (m_stall_cnt < 65535) m_stall_cnt++;
                m_run++;
            end else begin
                m_run = 0;
            end
            if (m_run >= 256) m_dead = 1'b1;
        end
        any = 1'b0;
        foreach (m_cnt[i]) if (m_cnt[i] != 0) any = 1'b1;
        #1;
        chk("busy", {31'd0, bus.busy}, {31'd0, any});
        chk("stall_cnt", {16'd0, bus.stall_cnt}, m_stall_cnt);
        chk("deadlock", {31'd0, bus.deadlock}, {31'd0, m_dead});
        chk("sb_err", {31'd0, bus.sb_err}, {31'd0, m_err});
        @(negedge clk);
    endtask

    initial begin
        int pend [$];
        int wr, op;
        bit wbd;

        foreach (m_cnt[i]) m_cnt[i] = 0;
        rst          = 1'b1;
        bus.id_valid = 1'b0;
        bus.inst     = '0;
        bus.svpc     = 1'b0;
        bus.wb_done  = 1'b0;
        bus.wb_rd    = '0;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_busy", {31'd0, bus.busy}, 0);
        chk("rst_stall_cnt", {16'd0, bus.stall_cnt}, 0);
        chk("rst_deadlock", {31'd0, bus.deadlock}, 0);
        chk("rst_sb_err", {31'd0, bus.sb_err}, 0);
        chk("rst_stall", {31'd0, bus.stall}, 0);
        @(negedge clk);

        // RAW on rs1, released by wb_done with one cycle of wakeup latency
        cyc(0, 1, 0, 5, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 6, 5, 0, 0, 0, 0, 1);
        cyc(0, 1, 0, 6, 5, 0, 0, 1, 5, 1);
        cyc(0, 1, 0, 6, 5, 0, 0, 0, 0, 0);

        // svpc masks the rs1 read
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, -1);
        cyc(0, 1, 0, 5, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 20, 5, 0, 1, 0, 0, 0);
        cyc(0, 1, 0, 21, 5, 0, 0, 0, 0, 1);

        // Saturation guard on rd
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, -1);
        cyc(0, 1, 4, 9, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 4, 9, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 4, 9, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 4, 9, 0, 0, 0, 0, 0, 1);
        cyc(0, 1, 4, 9, 0, 0, 0, 1, 9, 1);
        cyc(0, 1, 4, 9, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 4, 9, 0, 0, 0, 0, 0, 1);

        // Same-edge inc and dec on one register cancel
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, -1);
        cyc(0, 1, 4, 7, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 4, 7, 0, 0, 0, 1, 7, 0);
        chk("t4_busy", {31'd0, bus.busy}, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 7, 0);
        chk("t4_drained", {31'd0, bus.busy}, 0);
        chk("t4_no_err", {31'd0, bus.sb_err}, 0);

        // Underflow, then reset clears everything
        cyc(0, 1, 4, 3, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 12, 0);
        chk("t5_sb_err", {31'd0, bus.sb_err}, 1);
        chk("t5_busy", {31'd0, bus.busy}, 1);
        cyc(1, 1, 4, 3, 0, 0, 0, 1, 3, -1);
        chk("t5_rst_sb_err", {31'd0, bus.sb_err}, 0);
        chk("t5_rst_busy", {31'd0, bus.busy}, 0);

        // Watchdog trips after exactly 256 consecutive stall cycles
        cyc(0, 1, 0, 5, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 255; i++) cyc(0, 1, 0, 6, 5, 0, 0, 0, 0, 1);
        chk("t6_pre_deadlock", {31'd0, bus.deadlock}, 0);
        cyc(0, 1, 0, 6, 5, 0, 0, 0, 0, 1);
        chk("t6_deadlock", {31'd0, bus.deadlock}, 1);
        chk("t6_stall_cnt", {16'd0, bus.stall_cnt}, 256);
        cyc(0, 1, 0, 6, 5, 0, 0, 1, 5, 1);
        cyc(0, 1, 0, 6, 5, 0, 0, 0, 0, 0);
        chk("t6_sticky", {31'd0, bus.deadlock}, 1);

        // Randomized traffic over a small register window to provoke hazards
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, -1);
        repeat (1500) begin
            pend.delete();
            for (int k = 0; k < 8; k++) if (m_cnt[k] != 0) pend.push_back(k);
            wbd = ($urandom_range(1, 0) == 1);
            if (pend.size() > 0 && $urandom_range(3, 0) != 0)
                wr = pend[$urandom_range(pend.size() - 1, 0)];
            else
                wr = $urandom_range(7, 0);
            op = $urandom_range(15, 0);
            cyc(($urandom_range(99, 0) == 0), ($urandom_range(3, 0) != 0), op,
                $urandom_range(7, 0), $urandom_range(7, 0), $urandom_range(7, 0),
                ($urandom_range(3, 0) == 0), wbd, wr, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
